// File: rtl/gcd_engine.sv
// Iterative subtract-and-swap GCD engine, one request in flight, valid/ready on both sides.
// Latency out_cycles+1 edges from acceptance; result held in DONE until the consumer takes it.
module gcd_engine #(
  parameter int WIDTH = 8,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_gcd,
  output logic [TAG_W-1:0] out_tag,
  output logic [WIDTH+1:0] out_cycles
);

  localparam int CW = WIDTH + 2;
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] gcd_q, gcd_d;
  logic [TAG_W-1:0] otag_q, otag_d;
  logic [CW-1:0]    ocyc_q, ocyc_d;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    gcd_d   = gcd_q;
    otag_d  = otag_q;
    ocyc_d  = ocyc_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          a_d     = in_a;
          b_d     = in_b;
          tag_d   = in_tag;
          cnt_d   = '0;
          state_d = S_CALC;
        end
      end
      S_CALC: begin
        // The count includes the B==0 detection cycle itself.
        cnt_d = cnt_q + CNT_ONE;
        if (b_q == '0) begin
          gcd_d   = a_q;
          ocyc_d  = cnt_q + CNT_ONE;
          otag_d  = tag_q;
          state_d = S_DONE;
        end else if (a_q < b_q) begin
          a_d = b_q;
          b_d = a_q;
        end else begin
          a_d = a_q - b_q;
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      gcd_q   <= '0;
      otag_q  <= '0;
      ocyc_q  <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      gcd_q   <= gcd_d;
      otag_q  <= otag_d;
      ocyc_q  <= ocyc_d;
    end
  end

  // Handshake outputs come straight from the state register.
  assign in_ready   = (state_q == S_IDLE);
  assign out_valid  = (state_q == S_DONE);
  assign out_gcd    = gcd_q;
  assign out_tag    = otag_q;
  assign out_cycles = ocyc_q;

endmodule

// File: tb/tb_gcd_engine.sv
// Bench for gcd_engine: directed table plus randomized pairs against a Euclid-based model,
// on an 8-bit/4-bit-tag instance and a 16-bit/8-bit-tag instance.
module tb_gcd_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       i8_vld, i8_rdy, o8_vld, o8_rdy;
  logic [7:0] i8_a, i8_b, o8_gcd;
  logic [3:0] i8_tag, o8_tag;
  logic [9:0] o8_cyc;

  logic        i16_vld, i16_rdy, o16_vld, o16_rdy;
  logic [15:0] i16_a, i16_b, o16_gcd;
  logic [7:0]  i16_tag, o16_tag;
  logic [17:0] o16_cyc;

  gcd_engine #(.WIDTH(8), .TAG_W(4)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(i8_vld), .in_ready(i8_rdy), .in_a(i8_a), .in_b(i8_b), .in_tag(i8_tag),
    .out_valid(o8_vld), .out_ready(o8_rdy), .out_gcd(o8_gcd), .out_tag(o8_tag),
    .out_cycles(o8_cyc)
  );

  gcd_engine #(.WIDTH(16), .TAG_W(8)) dut16 (
    .clk(clk), .rst(rst),
    .in_valid(i16_vld), .in_ready(i16_rdy), .in_a(i16_a), .in_b(i16_b), .in_tag(i16_tag),
    .out_valid(o16_vld), .out_ready(o16_rdy), .out_gcd(o16_gcd), .out_tag(o16_tag),
    .out_cycles(o16_cyc)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  tag;
    longint      g;
    longint      c;
  } vec_t;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Euclid by division: each step (a,b) with b!=0 costs a/b subtractions plus one swap,
  // and the final B==0 detection costs one more cycle.
  function automatic void model(input longint a_in, input longint b_in,
                                output longint g, output longint c);
    longint a, b, t;
    a = a_in;
    b = b_in;
    c = 1;
    while (b != 0) begin
      c += a / b + 1;
      t = a % b;
      a = b;
      b = t;
    end
    g = a;
  endfunction

  function automatic logic [63:0] f_ov(input bit w);
    return w ? {63'b0, o16_vld} : {63'b0, o8_vld};
  endfunction
  function automatic logic [63:0] f_rdy(input bit w);
    return w ? {63'b0, i16_rdy} : {63'b0, i8_rdy};
  endfunction
  function automatic logic [63:0] f_gcd(input bit w);
    return w ? {48'b0, o16_gcd} : {56'b0, o8_gcd};
  endfunction
  function automatic logic [63:0] f_tag(input bit w);
    return w ? {56'b0, o16_tag} : {60'b0, o8_tag};
  endfunction
  function automatic logic [63:0] f_cyc(input bit w);
    return w ? {46'b0, o16_cyc} : {54'b0, o8_cyc};
  endfunction

  task automatic drive(input bit w, input bit v, input logic [15:0] a, input logic [15:0] b,
                       input logic [7:0] tag);
    if (w) begin
      i16_vld = v; i16_a = a; i16_b = b; i16_tag = tag;
    end else begin
      i8_vld = v; i8_a = a[7:0]; i8_b = b[7:0]; i8_tag = tag[3:0];
    end
  endtask

  // Called at a negedge with the engine idle; returns at the negedge where out_valid is seen.
  task automatic run_one(input bit w, input logic [15:0] a, input logic [15:0] b,
                         input logic [7:0] tag, input bit noise, input string nm,
                         input longint exp_c);
    int lat;
    check({nm, " in_ready before request"}, f_rdy(w), 64'd1);
    drive(w, 1'b1, a, b, tag);
    @(posedge clk);
    lat = 1;
    @(negedge clk);
    drive(w, 1'b0, 16'h0, 16'h0, 8'h0);
    while (f_ov(w) == 64'd0 && longint'(lat) < exp_c + 20) begin
      if (noise) begin
        check({nm, " in_ready low while busy"}, f_rdy(w), 64'd0);
        drive(w, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 8'($urandom));
      end
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    drive(w, 1'b0, 16'h0, 16'h0, 8'h0);
    check({nm, " edges to out_valid"}, 64'(lat), 64'(exp_c + 1));
    if (f_ov(w) == 64'd0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  task automatic check_result(input bit w, input string nm, input longint g,
                              input logic [7:0] tag, input longint c);
    check({nm, " out_gcd"}, f_gcd(w), 64'(g));
    check({nm, " out_tag"}, f_tag(w), w ? {56'b0, tag} : {60'b0, tag[3:0]});
    check({nm, " out_cycles"}, f_cyc(w), 64'(c));
  endtask

  task automatic accept();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_pair(input bit w, input string nm, input longint cap);
    logic [15:0] a, b;
    logic [7:0]  tag;
    longint g, c;
    do begin
      a = w ? 16'($urandom) : {8'h0, 8'($urandom)};
      b = w ? 16'($urandom) : {8'h0, 8'($urandom)};
      model(longint'(a), longint'(b), g, c);
    end while (c > cap);
    tag = 8'($urandom);
    run_one(w, a, b, tag, 1'b0, nm, c);
    check_result(w, nm, g, tag, c);
    accept();
  endtask

  vec_t tbl[8];

  initial begin
    longint g, c;
    rst = 1'b1;
    o8_rdy = 1'b1;
    o16_rdy = 1'b1;
    drive(1'b0, 1'b0, 16'h0, 16'h0, 8'h0);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 8'h0);

    tbl[0] = '{a: 16'd27, b: 16'd15,  tag: 8'd5,  g: 3,  c: 10};
    tbl[1] = '{a: 16'd12, b: 16'd0,   tag: 8'd1,  g: 12, c: 1};
    tbl[2] = '{a: 16'd0,  b: 16'd12,  tag: 8'd2,  g: 12, c: 2};
    tbl[3] = '{a: 16'd0,  b: 16'd0,   tag: 8'd3,  g: 0,  c: 1};
    tbl[4] = '{a: 16'd9,  b: 16'd9,   tag: 8'd4,  g: 9,  c: 3};
    tbl[5] = '{a: 16'd21, b: 16'd14,  tag: 8'd9,  g: 7,  c: 6};
    tbl[6] = '{a: 16'd48, b: 16'd18,  tag: 8'd14, g: 6,  c: 9};
    tbl[7] = '{a: 16'd1,  b: 16'd255, tag: 8'd15, g: 1,  c: 258};

    @(negedge clk);
    check("reset in_ready", f_rdy(1'b0), 64'd1);
    check("reset out_valid", f_ov(1'b0), 64'd0);
    check_result(1'b0, "reset", 0, 8'h0, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d(%0d,%0d)", i, tbl[i].a, tbl[i].b);
      run_one(1'b0, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].c > 100, nm, tbl[i].c);
      check_result(1'b0, nm, tbl[i].g, tbl[i].tag, tbl[i].c);
      accept();
    end

    // Asynchronous reset between edges, with a non-zero result still on the outputs.
    #2 rst = 1'b1;
    #1;
    check("async rst in_ready", f_rdy(1'b0), 64'd1);
    check("async rst out_valid", f_ov(1'b0), 64'd0);
    check_result(1'b0, "async rst", 0, 8'h0, 0);
    @(negedge clk);
    rst = 1'b0;

    // Consumer stall: result must stay put and no new request may be taken.
    o8_rdy = 1'b0;
    run_one(1'b0, 16'd48, 16'd18, 8'd6, 1'b0, "bp", 9);
    for (int k = 0; k < 7; k++) begin
      @(posedge clk);
      @(negedge clk);
      check("bp out_valid held", f_ov(1'b0), 64'd1);
      check("bp in_ready low", f_rdy(1'b0), 64'd0);
      check_result(1'b0, "bp held", 6, 8'd6, 9);
    end
    o8_rdy = 1'b1;
    accept();
    check("bp after accept out_valid", f_ov(1'b0), 64'd0);
    run_one(1'b0, 16'd100, 16'd75, 8'd7, 1'b0, "bp next", 7);
    check_result(1'b0, "bp next", 25, 8'd7, 7);
    accept();

    // Reset in the middle of a long calculation, then a fresh request.
    drive(1'b0, 1'b1, 16'd1, 16'd255, 8'd8);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 16'h0, 8'h0);
    repeat (30) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midcalc rst in_ready", f_rdy(1'b0), 64'd1);
    check("midcalc rst out_valid", f_ov(1'b0), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_one(1'b0, 16'd21, 16'd14, 8'd10, 1'b0, "after rst", 6);
    check_result(1'b0, "after rst", 7, 8'd10, 6);
    accept();

    for (int i = 0; i < 30; i++) rand_pair(1'b0, $sformatf("rnd8_%0d", i), 1000);

    run_one(1'b1, 16'd65535, 16'd1, 8'hA5, 1'b0, "w16 worst", 65537);
    check_result(1'b1, "w16 worst", 1, 8'hA5, 65537);
    accept();

    drive(1'b1, 1'b1, 16'd65535, 16'd1, 8'h11);
    @(posedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 16'h0, 16'h0, 8'h0);
    repeat (50) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("w16 midcalc rst in_ready", f_rdy(1'b1), 64'd1);
    check_result(1'b1, "w16 midcalc rst", 0, 8'h0, 0);
    @(negedge clk);
    rst = 1'b0;
    model(21, 14, g, c);
    run_one(1'b1, 16'd21, 16'd14, 8'hC3, 1'b0, "w16 after rst", c);
    check_result(1'b1, "w16 after rst", g, 8'hC3, c);
    accept();

    for (int i = 0; i < 12; i++) rand_pair(1'b1, $sformatf("rnd16_%0d", i), 500);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
